// File: rtl/axi_regm_pkg.sv
// axi_regm_pkg: state encoding and fixed AXI field values shared by axi_reg_master
package axi_regm_pkg;
    typedef enum logic [2:0] {IDLE, W_REQ, W_RESP, R_REQ, R_RESP, RSP} regm_state_t;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
    localparam logic [2:0] SIZE_4B = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
endpackage

// File: rtl/axi_ifc.sv
// axi_ifc: 32-bit AXI4 bundle with a master modport; ID width set by ID_W
interface axi_ifc #(parameter int ID_W = 4);
    logic [ID_W-1:0] awid;
    logic [31:0] awaddr;
    logic [7:0] awlen;
    logic [2:0] awsize;
    logic [1:0] awburst;
    logic awlock;
    logic [3:0] awcache;
    logic [2:0] awprot;
    logic awvalid, awready;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    logic wlast, wvalid, wready;
    logic [ID_W-1:0] bid;
    logic [1:0] bresp;
    logic bvalid, bready;
    logic [ID_W-1:0] arid;
    logic [31:0] araddr;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst;
    logic arlock;
    logic [3:0] arcache;
    logic [2:0] arprot;
    logic arvalid, arready;
    logic [ID_W-1:0] rid;
    logic [31:0] rdata;
    logic [1:0] rresp;
    logic rlast, rvalid, rready;
    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_regm_watchdog.sv
// axi_regm_watchdog: response watchdog; load clears, en counts, expire at LIMIT-1
// Ports: clk, rst_n (async active-low), load, en, expire
module axi_regm_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(LIMIT);
    logic [W-1:0] count;
    assign expire = en && (count == W'(LIMIT - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (load) count <= '0;
        else if (en && !expire) count <= count + 1'b1;
    end
endmodule

// File: rtl/axi_reg_master.sv
// axi_reg_master: single-outstanding AXI initiator turning register commands into one-beat reads/writes
// Ports: clk, rst_n (async active-low); m (AXI master); cmd valid/ready/write/addr/wdata;
//        rsp valid/ready/rdata/resp; rsp_timeout only when AXI_REGM_TIMEOUT_EN is defined
module axi_reg_master
    import axi_regm_pkg::*;
#(
    parameter int ID_VALUE = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    axi_ifc.master      m,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic [31:0] i_cmd_addr,
    input  logic [31:0] i_cmd_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic [1:0]  o_rsp_resp
`ifdef AXI_REGM_TIMEOUT_EN
    ,
    output logic        o_rsp_timeout
`endif
);
    localparam int ID_W = $bits(m.awid);
    regm_state_t state, state_n;
    logic awvalid, wvalid, bready, arvalid, rready;
    logic awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n, cmd_ready_n, rsp_valid_n;
    logic [31:0] addr, wdata;
    logic cmd_hs, expire;
`ifdef AXI_REGM_TIMEOUT_EN
    localparam bit DRAIN = 1'b1;
    logic busy;
    assign busy = state inside {W_REQ, W_RESP, R_REQ, R_RESP};
    axi_regm_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
        .clk(clk), .rst_n(rst_n), .load(cmd_hs), .en(busy), .expire(expire)
    );
`else
    localparam bit DRAIN = 1'b0;
    assign expire = 1'b0;
`endif
    assign cmd_hs = i_cmd_valid && o_cmd_ready;
    assign m.awid = ID_W'(ID_VALUE);
    assign m.arid = ID_W'(ID_VALUE);
    assign m.awaddr = addr;
    assign m.araddr = addr;
    assign m.wdata = wdata;
    assign m.awlen = 8'h00;
    assign m.arlen = 8'h00;
    assign m.awsize = SIZE_4B;
    assign m.arsize = SIZE_4B;
    assign m.awburst = BURST_INCR;
    assign m.arburst = BURST_INCR;
    assign m.awlock = 1'b0;
    assign m.arlock = 1'b0;
    assign m.awcache = 4'h0;
    assign m.arcache = 4'h0;
    assign m.awprot = 3'h0;
    assign m.arprot = 3'h0;
    assign m.wstrb = 4'hF;
    assign m.wlast = 1'b1;
    assign m.awvalid = awvalid;
    assign m.wvalid = wvalid;
    assign m.bready = bready;
    assign m.arvalid = arvalid;
    assign m.rready = rready;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = cmd_hs ? (i_cmd_write ? W_REQ : R_REQ) : IDLE;
            // a dropped valid means that channel already handshook
            W_REQ:   state_n = ((!awvalid || m.awready) && (!wvalid || m.wready)) ? W_RESP : W_REQ;
            W_RESP:  state_n = m.bvalid ? RSP : W_RESP;
            R_REQ:   state_n = m.arready ? R_RESP : R_REQ;
            R_RESP:  state_n = m.rvalid ? RSP : R_RESP;
            RSP:     state_n = i_rsp_ready ? IDLE : RSP;
            default: state_n = IDLE;
        endcase
        if (expire) state_n = RSP;
        awvalid_n = (state_n == W_REQ) && ((state == IDLE) || (awvalid && !m.awready));
        wvalid_n = (state_n == W_REQ) && ((state == IDLE) || (wvalid && !m.wready));
        arvalid_n = (state_n == R_REQ);
        // with the watchdog, IDLE keeps both response readies up to swallow late responses
        bready_n = (state_n == W_RESP) || (DRAIN && state_n == IDLE);
        rready_n = (state_n == R_RESP) || (DRAIN && state_n == IDLE);
        cmd_ready_n = (state_n == IDLE);
        rsp_valid_n = (state_n == RSP);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            {awvalid, wvalid, bready, arvalid, rready, o_cmd_ready, o_rsp_valid} <= '0;
        end else begin
            state <= state_n;
            {awvalid, wvalid, bready, arvalid, rready, o_cmd_ready, o_rsp_valid} <=
                {awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n, cmd_ready_n, rsp_valid_n};
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            wdata <= '0;
            o_rsp_rdata <= '0;
            o_rsp_resp <= OKAY;
`ifdef AXI_REGM_TIMEOUT_EN
            o_rsp_timeout <= 1'b0;
`endif
        end else begin
            if (cmd_hs) begin
                addr <= i_cmd_addr & ~32'h3;
                wdata <= i_cmd_wdata;
                o_rsp_rdata <= '0;
                o_rsp_resp <= OKAY;
`ifdef AXI_REGM_TIMEOUT_EN
                o_rsp_timeout <= 1'b0;
`endif
            end
            if (state == W_RESP && m.bvalid) o_rsp_resp <= m.bresp;
            if (state == R_RESP && m.rvalid) begin
                o_rsp_rdata <= m.rdata;
                o_rsp_resp <= m.rresp;
            end
`ifdef AXI_REGM_TIMEOUT_EN
            if (expire) begin
                o_rsp_rdata <= '0;
                o_rsp_resp <= SLVERR;
                o_rsp_timeout <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: doc/axi_reg_master.md
# axi_reg_master

Single-outstanding AXI initiator that turns a simple register command port into one-beat AXI reads and writes. It is the master-side counterpart to the register bridge: CPU-less test logic, sequencers or debug engines drive it to poke register files that sit behind AXI slaves. Exactly one transaction is in flight at a time, and every transfer is a 32-bit single-beat burst.

## Interface
- ID_VALUE, 0: constant used for m.awid and m.arid.
- TIMEOUT_CYCLES, 1024: response watchdog limit. Used only when the timeout feature is compiled in. Must be at least 2.
- clk  input  1  sole clock.
- rst_n  input  1  asynchronous assert, active-low reset.
- m  axi_ifc.master  -  AXI master port. ID width is taken from $bits(m.awid).
- i_cmd_valid  input  1  command request.
- o_cmd_ready  output  1  command accepted when high together with i_cmd_valid.
- i_cmd_write  input  1  1 = write, 0 = read.
- i_cmd_addr  input  32  byte address. Bits [1:0] are ignored.
- i_cmd_wdata  input  32  write data.
- o_rsp_valid  output  1  result available.
- i_rsp_ready  input  1  result consumed when high together with o_rsp_valid.
- o_rsp_rdata  output  32  read data. Zero for writes.
- o_rsp_resp  output  2  captured BRESP or RRESP.
- o_rsp_timeout  output  1  watchdog fired. Exists only with AXI_REGM_TIMEOUT_EN.

## Operation
- States: IDLE, W_REQ, W_RESP, R_REQ, R_RESP, RSP.
- IDLE:
  - o_cmd_ready=1.
  - On handshake, latch the address with [1:0] forced to 0, plus the data and the write flag.
  - Go to W_REQ for writes or R_REQ for reads.
- W_REQ:
  - m.awvalid and m.wvalid both rise on entry.
  - Each valid drops independently on its own handshake.
  - When both handshakes are complete (same cycle or different cycles), go to W_RESP.
- W_RESP: m.bready=1. On m.bvalid, capture m.bresp and go to RSP.
- R_REQ: m.arvalid=1. On m.arready, go to R_RESP.
- R_RESP: m.rready=1. On m.rvalid, capture m.rdata and m.rresp, then go to RSP. m.rlast is ignored.
- RSP: o_rsp_valid=1, held until i_rsp_ready, then go to IDLE.
- Fixed AXI fields:
  - len=0, size=3'b010, burst=INCR.
  - wstrb=4'hF, wlast=1.
  - lock, cache and prot = 0.
- A nonzero RESP does not change the flow; it is only reported on o_rsp_resp.
- All AXI valid/ready outputs and o_cmd_ready, o_rsp_valid are registered. No combinational path runs from AXI inputs to AXI outputs.
- A response that arrives early (for example, bvalid while W_REQ is still waiting for wready) is not accepted until W_RESP.

## Timing
- Reset value of every output is 0: all m.*valid, m.bready, m.rready, o_cmd_ready, o_rsp_*, and addr/data buses.
- o_cmd_ready rises on the first clk edge after reset release.
- Minimum latencies, with the command handshake at cycle 0 and the slave ready at zero wait:
  - Write: AW/W valid in cycle 1, bready in cycle 2, bvalid earliest cycle 2, o_rsp_valid in cycle 3.
  - Read: arvalid in cycle 1, rvalid earliest cycle 2, o_rsp_valid in cycle 3.
- Back-to-back commands: a new command can be accepted 1 cycle after the RSP handshake (IDLE takes one cycle).
- Once asserted, AXI valids and payloads are held stable until their handshake, per AXI rules.
- Reset asserted mid-transaction clears all state and outputs immediately. This is allowed only when the system resets the slave in the same reset.

## Configuration
- AXI_REGM_TIMEOUT_EN defined:
  - A counter clears on entry to W_REQ or R_REQ and counts every cycle until the FSM reaches RSP.
  - When the counter reaches TIMEOUT_CYCLES-1, all AXI valids drop and the FSM goes to RSP with o_rsp_resp=2'b10, o_rsp_timeout=1 and o_rsp_rdata=0.
  - In IDLE, bready and rready are held at 1 so that late stray responses are absorbed and discarded.
  - This mode is for debug use only; abandoning an open handshake is a documented AXI violation.
- Not defined: no counter, no o_rsp_timeout port, and the block waits indefinitely.

## Structure
- Shared package axi_regm_pkg holds:
  - The state enum regm_state_t.
  - The RESP constants OKAY, EXOKAY, SLVERR, DECERR.
  - The fixed SIZE_4B and BURST_INCR constants.
- One sub-module, axi_regm_watchdog (load/enable/expire counter), is instantiated only under AXI_REGM_TIMEOUT_EN.

## Test plan
- Write 0x0000_0014 with data 0xDEADBEEF, slave ready immediately:
  - awaddr=0x14 and wdata=0xDEADBEEF in cycle 1.
  - o_rsp_valid in cycle 3 with resp=0.
- Write with wready delayed 3 cycles after awready:
  - awvalid drops alone first.
  - bready is not asserted until the W handshake completes.
  - Exactly one response is produced.
- Read 0x0000_0008 with the slave returning rdata=0x1234_5678, rresp=SLVERR after 5 wait cycles:
  - o_rsp_rdata=0x12345678 and o_rsp_resp=2'b10.
- Hold i_rsp_ready low for 4 cycles:
  - o_rsp_valid and the data stay stable.
  - o_cmd_ready stays 0 and the next command is not accepted.
- Assert rst_n low during R_RESP:
  - All outputs are 0 within the same cycle.
  - After release, a fresh read completes normally.
- With AXI_REGM_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts arready:
  - arvalid drops after 16 cycles.
  - o_rsp_timeout=1 and o_rsp_resp=2'b10.
